// File: rtl/swi_debounce.sv
// Synchronises and debounces NBITS raw switch lines into a clean registered level
// plus one-cycle rise/fall pulses; a change is accepted after STABLE consecutive cycles.
module swi_debounce #(
   parameter int NBITS  = 8,
   parameter int STABLE = 3
) (
   input  logic             clk_2,
   input  logic             reset_n,
   input  logic [NBITS-1:0] SWI,
   output logic [NBITS-1:0] sw_level,
   output logic [NBITS-1:0] sw_rise,
   output logic [NBITS-1:0] sw_fall,
   output logic             sw_busy
);

   localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   logic [NBITS-1:0] s1_q, s2_q;
   logic [NBITS-1:0] level_q, rise_q, fall_q;
   logic [NBITS-1:0] level_d, rise_d, fall_d;
   logic [CW-1:0]    cnt_q [NBITS];
   logic [CW-1:0]    cnt_d [NBITS];
   logic             busy;

   // The counter only runs while the synchronised input disagrees with the level,
   // so any return to the accepted value before STABLE cycles discards the change.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < NBITS; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = s2_q[i];
               rise_d[i]  = s2_q[i];
               fall_d[i]  = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NBITS; i++) begin
         busy = busy | (cnt_q[i] != '0);
      end
   end

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < NBITS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q    <= SWI;
         s2_q    <= s1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < NBITS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_level = level_q;
   assign sw_rise  = rise_q;
   assign sw_fall  = fall_q;
   assign sw_busy  = busy;

endmodule

// File: tb/tb_swi_debounce.sv
// Directed and randomised checks of swi_debounce against a run-length reference model.
module tb_swi_debounce;

   localparam int NB = 8;
   localparam int ST = 3;

   logic          clk_2 = 1'b0;
   logic          reset_n = 1'b0;
   logic [NB-1:0] SWI = '0;
   logic [NB-1:0] sw_level, sw_rise, sw_fall;
   logic          sw_busy;

   int total = 0;
   int bad   = 0;

   // Reference model: the input seen by the debouncer is SWI delayed two edges;
   // a bit's level flips once that delayed input has disagreed for ST edges in a row.
   logic [NB-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall;
   int            m_run [NB];

   swi_debounce #(.NBITS(NB), .STABLE(ST)) dut (
      .clk_2   (clk_2),
      .reset_n (reset_n),
      .SWI     (SWI),
      .sw_level(sw_level),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall),
      .sw_busy (sw_busy)
   );

   always #5 clk_2 = ~clk_2;

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
   endtask

   task automatic model_edge(input logic [NB-1:0] v);
      if (!reset_n) return;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < NB; i++) begin
         if (m_d2[i] != m_lvl[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == ST) begin
               m_lvl[i]  = m_d2[i];
               m_rise[i] = m_d2[i];
               m_fall[i] = !m_d2[i];
               m_run[i]  = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_d2 = m_d1;
      m_d1 = v;
   endtask

   function automatic logic model_busy();
      logic b = 1'b0;
      for (int i = 0; i < NB; i++) b = b | (m_run[i] > 0);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".level"}, 32'(sw_level), 32'(m_lvl));
      chk({tag, ".rise"},  32'(sw_rise),  32'(m_rise));
      chk({tag, ".fall"},  32'(sw_fall),  32'(m_fall));
      chk({tag, ".busy"},  32'(sw_busy),  32'(model_busy()));
   endtask

   // Drive a value, take one edge, then sample 1 time unit later.
   task automatic step(input logic [NB-1:0] v, input string tag);
      SWI = v;
      @(posedge clk_2);
      model_edge(v);
      #1;
      chk_model(tag);
   endtask

   task automatic settle(input logic [NB-1:0] v, input string tag);
      for (int k = 0; k < 7; k++) step(v, tag);
   endtask

   initial begin
      model_reset();

      // Reset held with all switches high
      SWI = 8'hFF;
      repeat (3) @(posedge clk_2);
      #1;
      chk("rst.level", 32'(sw_level), 32'h0);
      chk("rst.rise",  32'(sw_rise),  32'h0);
      chk("rst.fall",  32'(sw_fall),  32'h0);
      chk("rst.busy",  32'(sw_busy),  32'h0);
      #2 reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) step(8'hFF, "rel");
      chk("rel.e3.level", 32'(sw_level), 32'h0);
      step(8'hFF, "rel.e4");
      chk("rel.e4.level", 32'(sw_level), 32'hFF);
      chk("rel.e4.rise",  32'(sw_rise),  32'hFF);
      step(8'hFF, "rel.e5");
      chk("rel.e5.rise",  32'(sw_rise),  32'h0);

      // Clean press on bit 0
      settle(8'h00, "clr");
      chk("clr.level", 32'(sw_level), 32'h0);
      step(8'h01, "press.e0");
      step(8'h01, "press.e1");
      chk("press.e1.busy", 32'(sw_busy), 32'h0);
      step(8'h01, "press.e2");
      chk("press.e2.busy", 32'(sw_busy), 32'h1);
      step(8'h01, "press.e3");
      chk("press.e3.busy", 32'(sw_busy), 32'h1);
      step(8'h01, "press.e4");
      chk("press.e4.level", 32'(sw_level[0]), 32'h1);
      chk("press.e4.rise",  32'(sw_rise[0]),  32'h1);
      chk("press.e4.busy",  32'(sw_busy),     32'h0);
      step(8'h01, "press.e5");
      chk("press.e5.rise",  32'(sw_rise[0]),  32'h0);
      chk("press.e5.fall",  32'(sw_fall),     32'h0);

      // Bounce on bit 3, then hold high
      settle(8'h00, "bclr");
      step(8'h08, "bounce");
      step(8'h00, "bounce");
      step(8'h08, "bounce");
      step(8'h00, "bounce");
      for (int k = 1; k <= 4; k++) begin
         step(8'h08, "bhold");
         chk("bhold.norise", 32'(sw_rise[3]), 32'h0);
      end
      step(8'h08, "bhold.e4");
      chk("bhold.e4.rise", 32'(sw_rise[3]), 32'h1);
      step(8'h08, "bhold.e5");
      chk("bhold.e5.rise", 32'(sw_rise[3]), 32'h0);

      // Two-cycle glitch on bit 5
      settle(8'h00, "gclr");
      step(8'h20, "glitch");
      step(8'h20, "glitch");
      for (int k = 0; k < 6; k++) begin
         step(8'h00, "gpost");
         chk("gpost.level5", 32'(sw_level[5]), 32'h0);
         chk("gpost.rise",   32'(sw_rise),     32'h0);
      end
      chk("gpost.busy", 32'(sw_busy), 32'h0);

      // All lanes changing together
      settle(8'h0F, "lanes.pre");
      for (int k = 0; k < 4; k++) step(8'hF0, "lanes");
      step(8'hF0, "lanes.e4");
      chk("lanes.e4.level", 32'(sw_level), 32'hF0);
      chk("lanes.e4.rise",  32'(sw_rise),  32'hF0);
      chk("lanes.e4.fall",  32'(sw_fall),  32'h0F);
      step(8'hF0, "lanes.e5");
      chk("lanes.e5.rise",  32'(sw_rise),  32'h0);
      chk("lanes.e5.fall",  32'(sw_fall),  32'h0);

      // Reset pulsed while bit 1 is mid-count
      settle(8'h00, "mrclr");
      step(8'h02, "mr.e0");
      step(8'h02, "mr.e1");
      step(8'h02, "mr.e2");
      chk("mr.e2.busy", 32'(sw_busy), 32'h1);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk_model("mr.inrst");
      chk("mr.inrst.busy", 32'(sw_busy), 32'h0);
      #2 reset_n = 1'b1;
      for (int k = 0; k < 4; k++) step(8'h02, "mr.post");
      chk("mr.post.e3.level", 32'(sw_level[1]), 32'h0);
      step(8'h02, "mr.post.e4");
      chk("mr.post.e4.level", 32'(sw_level[1]), 32'h1);
      chk("mr.post.e4.rise",  32'(sw_rise[1]),  32'h1);

      // Randomised switch activity with holds of varying length
      begin
         logic [NB-1:0] v;
         v = SWI;
         for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) v = NB'($urandom);
            else if ($urandom_range(0, 2) == 0) v = v ^ (NB'(1) << $urandom_range(0, NB - 1));
            step(v, "rand");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/swi_debounce.md
# swi_debounce

Input-conditioning stage between the board slide switches and the lab logic in `top`: each of the `NBITS` raw `SWI` lines is synchronised to `clk_2`, debounced by a per-bit stability counter, and presented as a clean level plus one-cycle rise/fall pulses. `top` uses `sw_level` in place of `SWI` for the combinational vault/greenhouse functions. `sw_rise`/`sw_fall` are for edge-triggered logic.

## Interface
- `NBITS`, default 8: number of switch lines.
- `STABLE`, default 3: consecutive synchronised cycles a new value must hold before it is accepted. Legal range is ≥1.
- `CW`, derived as max(1, $clog2(STABLE)): width of each per-bit counter. Not user-set.

Ports:
- `clk_2`  in  1: the only clock. All state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `SWI`  in  NBITS: raw switch inputs, asynchronous to `clk_2`, may bounce.
- `sw_level`  out  NBITS: debounced, registered switch level.
- `sw_rise`  out  NBITS: registered one-cycle pulse when `sw_level[i]` goes 0→1.
- `sw_fall`  out  NBITS: registered one-cycle pulse when `sw_level[i]` goes 1→0.
- `sw_busy`  out  1: high while any bit's counter is non-zero. It is the OR of the counter-nonzero flags, decoded from registers only.

## Operation
- Each bit i is independent and has the following state:
  - `s1[i]`, `s2[i]`: two-flop synchroniser.
  - `cnt[i]`: CW-bit counter.
  - `sw_level[i]`, `sw_rise[i]`, `sw_fall[i]`.
- Synchroniser, every edge: `s1 <= SWI`, then `s2 <= s1`. No logic between the two flops.
- Debounce, every edge, per bit:
  - If `s2 == sw_level`: `cnt <= 0`. `rise`/`fall` go to 0.
  - Else, if `cnt == STABLE-1`:
    - `sw_level <= s2` and `cnt <= 0`.
    - `sw_rise <= s2`.
    - `sw_fall <= ~s2`.
  - Else: `cnt <= cnt+1`. `rise`/`fall` go to 0.
- Glitch rejection: if `s2` returns to `sw_level` before `STABLE` consecutive differing cycles, the counter clears and nothing is emitted.
- `sw_rise[i]` and `sw_fall[i]` are never high together.
- Each pulse is exactly one cycle, because `sw_level` matches `s2` on the following edge.
- Counter never exceeds STABLE-1, so there is no wrap-around.
- Bits on different lanes changing on the same edge are processed independently. Multiple `rise`/`fall` bits may assert in the same cycle.

## Timing
- Reset (`reset_n` low, asynchronous): `s1`, `s2`, `cnt`, `sw_level`, `sw_rise`, `sw_fall` all 0. `sw_busy` is therefore 0.
- Release of reset takes effect on the next `clk_2` edge. There is no synchronous reset path.
- Latency, with SWI stable from before edge E0 (E0 captures into `s1`):
  - `s2` updates at E1.
  - `sw_level` and the pulse update at E(1+STABLE).
  - The pulse is visible for the cycle E(1+STABLE)..E(2+STABLE).
  - With `STABLE=3`: `sw_level` changes at E4. With `STABLE=1`: it changes at E2.
- `sw_busy` rises at E2 for a held change, for `STABLE≥2`. It falls on the edge that updates `sw_level`. For `STABLE=1` it never asserts.
- Switch high at reset release:
  - Treated as a normal 0→1 change.
  - `sw_level` rises after the latency above, with one `sw_rise` pulse. This is required behaviour.
- Reset asserted mid-count: all state clears immediately. No pulse is emitted.
- After release, the count restarts from 0.

## Test plan
- Reset check: `reset_n`=0 with `SWI`=8'hFF → all outputs 0 while held. Release → `sw_level`=8'hFF at E4 (`STABLE=3`) and `sw_rise`=8'hFF for exactly one cycle.
- Clean press: `SWI[0]` 0→1 held → `sw_busy` high at E2–E3, `sw_level[0]`=1 and `sw_rise[0]`=1 at E4. Then `sw_rise[0]`=0 at E5. `sw_fall` stays 0.
- Bounce: `SWI[3]` toggles 1,0,1,0 every cycle, then holds 1 → no pulse during toggling. A single `sw_rise[3]` occurs exactly STABLE+1 edges after the last toggle is captured.
- Short glitch: `SWI[5]` high for 2 cycles only (`STABLE=3`) → `sw_level[5]` stays 0, no pulses, `sw_busy` returns to 0.
- Simultaneous lanes: `SWI` 8'h0F→8'hF0 in one step → at E4, `sw_level`=8'hF0, `sw_rise`=8'hF0, `sw_fall`=8'h0F, each for one cycle.
- Reset mid-count: `SWI[1]` rises, `reset_n` pulsed low at E2 → outputs 0 immediately. After release with `SWI[1]` still high, `sw_level[1]` rises 4 edges after the first post-release edge.
